i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (slave) responder: the far end of the init-sequence I2C master.
- Lets the master's 16-bit register writes ({reg_addr, data}) and bus reads be checked in simulation and loop-back tests, and serves as an on-chip register port.
- Decodes START/STOP, matches a 7-bit device address, ACKs, and presents register writes on a one-cycle strobe.
- Serves reads from an external register file with auto-incrementing address.

Parameters:
- TARGET_ADDR, 7'h10, 7-bit device address the block responds to.
- SYNC_STAGES, 2, synchronizer depth on scl_di/sda_di (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 20x the SCL rate.
- areset_n  input  1  reset, asynchronous, active-low.
- scl_di  input  1  SCL as seen at the pad.
- sda_di  input  1  SDA as seen at the pad.
- sda_oe  output  1  1 = pull SDA low (drives the pad tristate); 0 = release.
- wr_valid  output  1  one-clk strobe: wr_addr/wr_data are valid.
- wr_addr  output  8  register address of the write.
- wr_data  output  8  write data byte.
- rd_addr  output  8  register address for the current or next read.
- rd_data  input  8  read data for rd_addr; combinational from the register file.
- busy  output  1  high from the matched-address ACK until STOP or repeated START.

Behaviour:
- Reset: sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, pointer=0, state IDLE.
- Reset mid-transfer releases SDA immediately, because the reset is asynchronous.
- Input conditioning:
  - scl_di and sda_di pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copies: scl_rise, scl_fall.
  - START = sda falling while scl high; STOP = sda rising while scl high.
- Bit timing:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on scl_fall, except STOP/START, which release it at once.
  - A 3-bit counter counts bits in a byte, MSB first.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START or repeated START, from any state -> DEV_ADDR, bit count 0, busy=0.
- STOP, from any state -> IDLE, sda_oe=0, busy=0.
- DEV_ADDR:
  - After 8 sampled bits, compare the top 7 bits with TARGET_ADDR.
  - Mismatch -> WAIT_STOP, never drives SDA.
  - Match -> DEV_ACK: assert sda_oe at the next scl_fall, set busy=1.
- DEV_ACK:
  - At the following scl_fall, R/W=0 -> REG_ADDR and sda_oe=0.
  - R/W=1 -> RD_DATA: latch rd_data into the shift register and drive its MSB (sda_oe = ~bit).
- REG_ADDR: 8 bits -> load the pointer, then ACK (REG_ACK) -> WR_DATA.
- WR_DATA:
  - On the 8th scl_rise: wr_addr=pointer, wr_data=byte, wr_valid=1 for exactly one clk (the clk after the sampled edge).
  - Then WR_ACK (ACK driven) -> WR_DATA, pointer+1.
- Pointer and rd_addr:
  - Pointer is 8-bit and wraps 8'hFF -> 8'h00.
  - rd_addr always equals the pointer.
- RD_DATA:
  - Shifts 8 bits out on scl_fall.
  - After the 8th bit, release SDA -> RD_ACK.
  - In RD_ACK, sample the master ACK on scl_rise and increment the pointer.
  - ACK (SDA=0) -> reload rd_data at the next scl_fall and continue.
  - NACK -> WAIT_STOP.
- Write-then-repeated-START-then-read uses the pointer set by the write phase.
- The target never stretches SCL; there is no output to SCL.
- The target only ever drives SDA low. It releases SDA within 1 clk after STOP and before the SCL high phase of any bit it does not own.

Test Plan:
- Write, two data bytes:
  - Stimulus: START, 0x20 (addr 0x10, W), 0x05, 0xA5, STOP.
  - Required: target ACKs all 3 bytes (sda_oe high across the 9th SCL pulse).
  - Required: one wr_valid pulse with wr_addr=0x05, wr_data=0xA5; busy falls at STOP.
- Burst write with wrap:
  - Stimulus: pointer 0xFF, data 0x11, 0x22.
  - Required: writes (0xFF,0x11) then (0x00,0x22); exactly 2 wr_valid pulses.
- Address mismatch:
  - Stimulus: START, 0x22 (addr 0x11), 0x05, 0x33, STOP.
  - Required: sda_oe stays 0 throughout, no wr_valid, busy stays 0.
- Combined read:
  - Stimulus: write pointer 0x40, repeated START, 0x21, model returns rd_data = rd_addr ^ 0xFF, master ACKs then NACKs.
  - Required: bus bytes 0xBF then 0xBE; rd_addr ends at 0x42; sda_oe=0 after the NACK.
- Abort:
  - Stimulus: STOP injected mid-byte during RD_DATA while sda_oe=1.
  - Required: sda_oe=0 within 1 clk of detection, state IDLE.
  - Stimulus: areset_n low mid-write.
  - Required: all outputs at reset values asynchronously.
- Loop-back with the init-sequence master:
  - Stimulus: master connected, ROM of 65 16-bit words {reg, data}.
  - Required: 65 wr_valid pulses, each matching the ROM word in order.

Source files
------------

// File: rtl/i2c_target_if.sv
// i2c_target_if: bundles the pad-side I2C signals and the register-port signals of i2c_target.
//   scl_di, sda_di : SCL/SDA as seen at the pads
//   sda_oe         : 1 = pull SDA low
//   wr_valid/addr/data : register write strobe and payload
//   rd_addr/rd_data    : register read address and combinational read data
//   busy           : target is addressed
// Modports: slave = the target, master = the bus/register-file side.
interface i2c_target_if;
    logic       scl_di;
    logic       sda_di;
    logic       sda_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  scl_di, sda_di, rd_data,
        output sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output scl_di, sda_di, rd_data,
        input  sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
    );
endinterface

// File: rtl/i2c_target.sv
// i2c_target: I2C target responder with an 8-bit auto-incrementing register pointer.
// Writes ({reg_addr, data...}) appear as one-clk wr_valid strobes; reads are served from
// an external register file via rd_addr/rd_data. Never stretches SCL, only pulls SDA low.
// Ports:
//   clk      : system clock, >= 20x SCL rate
//   areset_n : asynchronous active-low reset
//   bus      : i2c_target_if.slave (pad signals + register port)
module i2c_target #(
    parameter logic [6:0]  TARGET_ADDR = 7'h10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        areset_n,
    i2c_target_if.slave bus
);
    typedef enum logic [3:0] {
        StIdle, StDevAddr, StDevAck, StRegAddr, StRegAck,
        StWrData, StWrAck, StRdData, StRdAck, StWaitStop
    } state_e;

    // Input conditioning; synchronizers reset high (idle bus) so no false START/STOP.
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;
    logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_di};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_di};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    state_e     r_state, w_state_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_done, w_done_next;      // 8 bits received, ACK decision pending at next fall
    logic       r_ack_ok, w_ack_ok_next;  // master ACKed the last read byte
    logic [7:0] r_ptr, w_ptr_next;
    logic       r_sda_oe, w_sda_oe_next;
    logic       r_busy, w_busy_next;
    logic       r_wr_valid, w_wr_valid_next;
    logic [7:0] r_wr_addr, w_wr_addr_next;
    logic [7:0] r_wr_data, w_wr_data_next;
    logic [7:0] w_byte;
    logic       w_last_bit;

    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    // State register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) r_state <= StIdle;
        else           r_state <= w_state_next;
    end

    // Next-state logic; START/STOP override everything
    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = StIdle;
        end else if (w_start) begin
            w_state_next = StDevAddr;
        end else if (w_scl_fall) begin
            case (r_state)
                StDevAddr: if (r_done) begin
                    w_state_next = (r_shift[7:1] == TARGET_ADDR) ? StDevAck : StWaitStop;
                end
                StDevAck:  w_state_next = r_shift[0] ? StRdData : StRegAddr;
                StRegAddr: if (r_done) w_state_next = StRegAck;
                StRegAck:  w_state_next = StWrData;
                StWrData:  if (r_done) w_state_next = StWrAck;
                StWrAck:   w_state_next = StWrData;
                StRdData:  if (w_last_bit) w_state_next = StRdAck;
                StRdAck:   w_state_next = r_ack_ok ? StRdData : StWaitStop;
                default:   ;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_done_next     = r_done;
        w_ack_ok_next   = r_ack_ok;
        w_ptr_next      = r_ptr;
        w_sda_oe_next   = r_sda_oe;
        w_busy_next     = r_busy;
        w_wr_valid_next = 1'b0;
        w_wr_addr_next  = r_wr_addr;
        w_wr_data_next  = r_wr_data;
        if (w_stop || w_start) begin
            w_sda_oe_next  = 1'b0;
            w_busy_next    = 1'b0;
            w_bit_cnt_next = 3'd0;
            w_done_next    = 1'b0;
        end else if (w_scl_rise) begin
            case (r_state)
                StDevAddr, StRegAddr, StWrData: begin
                    w_shift_next   = w_byte;
                    w_bit_cnt_next = r_bit_cnt + 3'd1;  // wraps to 0 after the 8th bit
                    w_done_next    = w_last_bit;
                    if (w_last_bit && r_state == StRegAddr) w_ptr_next = w_byte;
                    if (w_last_bit && r_state == StWrData) begin
                        w_wr_valid_next = 1'b1;
                        w_wr_addr_next  = r_ptr;
                        w_wr_data_next  = w_byte;
                    end
                end
                StRdAck: begin
                    w_ack_ok_next = ~w_sda;
                    w_ptr_next    = r_ptr + 8'd1;
                end
                default: ;
            endcase
        end else if (w_scl_fall) begin
            case (r_state)
                StDevAddr: if (r_done) begin
                    w_done_next = 1'b0;
                    if (r_shift[7:1] == TARGET_ADDR) begin
                        w_sda_oe_next = 1'b1;
                        w_busy_next   = 1'b1;
                    end
                end
                StRegAddr, StWrData: if (r_done) begin
                    w_done_next   = 1'b0;
                    w_sda_oe_next = 1'b1;
                end
                StDevAck, StRdAck: begin
                    w_bit_cnt_next = 3'd0;
                    // Read continues: latch the addressed byte and drive its MSB
                    if ((r_state == StDevAck) ? r_shift[0] : r_ack_ok) begin
                        w_shift_next  = bus.rd_data;
                        w_sda_oe_next = ~bus.rd_data[7];
                    end else begin
                        w_sda_oe_next = 1'b0;
                    end
                end
                StRegAck: w_sda_oe_next = 1'b0;
                StWrAck: begin
                    w_sda_oe_next = 1'b0;
                    w_ptr_next    = r_ptr + 8'd1;
                end
                StRdData: begin
                    if (w_last_bit) begin
                        w_sda_oe_next = 1'b0;  // hand SDA to the master for its ACK
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        w_shift_next   = {r_shift[6:0], 1'b0};
                        w_sda_oe_next  = ~r_shift[6];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_done     <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_ptr      <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 8'd0;
            r_wr_data  <= 8'd0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_done     <= w_done_next;
            r_ack_ok   <= w_ack_ok_next;
            r_ptr      <= w_ptr_next;
            r_sda_oe   <= w_sda_oe_next;
            r_busy     <= w_busy_next;
            r_wr_valid <= w_wr_valid_next;
            r_wr_addr  <= w_wr_addr_next;
            r_wr_data  <= w_wr_data_next;
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.busy     = r_busy;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.rd_addr  = r_ptr;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target. Emulates an open-drain I2C master, models
// the register file as rd_data = rd_addr ^ 8'hFF, and logs every wr_valid pulse.
module tb_i2c_target;
    localparam int Q = 5;  // clocks per quarter SCL period

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic ovr = 1'b0;  // lets the master win SDA to inject an abort STOP

    int checks = 0;
    int errors = 0;

    i2c_target_if bus_if ();

    assign bus_if.scl_di  = m_scl;
    assign bus_if.sda_di  = ovr ? m_sda : (m_sda & ~bus_if.sda_oe);
    assign bus_if.rd_data = bus_if.rd_addr ^ 8'hFF;

    i2c_target #(
        .TARGET_ADDR (7'h10),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Bus monitor
    int          wv_pulses = 0;
    int          wv_cycles = 0;
    int          oe_cycles = 0;
    int          busy_cycles = 0;
    logic        wv_prev = 1'b0;
    logic [15:0] wlog [0:255];

    always @(negedge clk) begin
        wv_prev <= bus_if.wr_valid;
        if (bus_if.wr_valid) begin
            wv_cycles <= wv_cycles + 1;
            if (!wv_prev) begin
                wlog[wv_pulses[7:0]] <= {bus_if.wr_addr, bus_if.wr_data};
                wv_pulses <= wv_pulses + 1;
            end
        end
        if (bus_if.sda_oe) oe_cycles <= oe_cycles + 1;
        if (bus_if.busy) busy_cycles <= busy_cycles + 1;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        m_sda = 1'b0; q();
        m_scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; q();
        m_scl = 1'b1; q();
        m_sda = 1'b1; q(); q();
    endtask

    task automatic wbits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; q();
            m_scl = 1'b1; q(); q();
            m_scl = 1'b0; q();
        end
    endtask

    // ACK slot: target must hold SDA low across the whole high phase
    task automatic ack_phase(output logic ack);
        logic a1;
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        a1 = bus_if.sda_oe; q();
        ack = a1 & bus_if.sda_oe;
        m_scl = 1'b0; q();
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        wbits(b);
        ack_phase(ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; q();
            m_scl = 1'b1; q();
            b[i] = bus_if.sda_di; q();
            m_scl = 1'b0; q();
        end
        m_sda = nack; q();
        m_scl = 1'b1; q(); q();
        m_scl = 1'b0; q();
        m_sda = 1'b1;
    endtask

    initial begin
        logic        ack;
        logic [7:0]  rb;
        logic [15:0] rom_word;
        int          base;
        int          oe0;
        int          busy0;
        int          cyc0;
        int          n;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", bus_if.sda_oe, 0);
        chk("rst_wr_valid", bus_if.wr_valid, 0);
        chk("rst_wr_addr", bus_if.wr_addr, 0);
        chk("rst_wr_data", bus_if.wr_data, 0);
        chk("rst_rd_addr", bus_if.rd_addr, 0);
        chk("rst_busy", bus_if.busy, 0);
        areset_n = 1'b1;
        q();

        // Write, two data bytes
        base = wv_pulses;
        cyc0 = wv_cycles;
        i2c_start();
        wbyte(8'h20, ack); chk("w_ack_dev", ack, 1);
        wbyte(8'h05, ack); chk("w_ack_reg", ack, 1);
        wbyte(8'hA5, ack); chk("w_ack_data", ack, 1);
        chk("w_busy_before_stop", bus_if.busy, 1);
        i2c_stop();
        chk("w_busy_after_stop", bus_if.busy, 0);
        chk("w_pulses", wv_pulses - base, 1);
        chk("w_pulse_width", wv_cycles - cyc0, 1);
        chk("w_word", wlog[base[7:0]], 16'h05A5);

        // Burst write with pointer wrap
        base = wv_pulses;
        i2c_start();
        wbyte(8'h20, ack);
        wbyte(8'hFF, ack);
        wbyte(8'h11, ack); chk("wrap_ack1", ack, 1);
        wbyte(8'h22, ack); chk("wrap_ack2", ack, 1);
        i2c_stop();
        chk("wrap_pulses", wv_pulses - base, 2);
        chk("wrap_word0", wlog[base[7:0]], 16'hFF11);
        chk("wrap_word1", wlog[8'(base + 1)], 16'h0022);
        chk("wrap_rd_addr", bus_if.rd_addr, 8'h01);

        // Address mismatch
        base  = wv_pulses;
        oe0   = oe_cycles;
        busy0 = busy_cycles;
        i2c_start();
        wbyte(8'h22, ack); chk("mm_ack_dev", ack, 0);
        wbyte(8'h05, ack);
        wbyte(8'h33, ack);
        i2c_stop();
        chk("mm_oe_cycles", oe_cycles - oe0, 0);
        chk("mm_busy_cycles", busy_cycles - busy0, 0);
        chk("mm_pulses", wv_pulses - base, 0);

        // Combined write-pointer / repeated START / read
        base = wv_pulses;
        i2c_start();
        wbyte(8'h20, ack);
        wbyte(8'h40, ack); chk("rd_ack_ptr", ack, 1);
        i2c_start();
        wbyte(8'h21, ack); chk("rd_ack_dev", ack, 1);
        rbyte(1'b0, rb); chk("rd_byte0", rb, 8'hBF);
        rbyte(1'b1, rb); chk("rd_byte1", rb, 8'hBE);
        chk("rd_oe_after_nack", bus_if.sda_oe, 0);
        chk("rd_rd_addr", bus_if.rd_addr, 8'h42);
        chk("rd_busy_until_stop", bus_if.busy, 1);
        i2c_stop();
        chk("rd_no_writes", wv_pulses - base, 0);

        // Abort: STOP during RD_DATA while driving a 0 (byte 0xBD, bit 6 = 0)
        i2c_start();
        wbyte(8'h21, ack);
        m_sda = 1'b1; q();
        m_scl = 1'b1; q(); q();
        m_scl = 1'b0; q();
        chk("abort_oe_driving", bus_if.sda_oe, 1);
        m_sda = 1'b0;
        ovr   = 1'b1; q();
        m_scl = 1'b1; q();
        m_sda = 1'b1;
        n = 0;
        while (bus_if.sda_oe && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("abort_oe_release_fast", (n <= 3), 1);
        ovr = 1'b0;
        q();
        chk("abort_busy", bus_if.busy, 0);
        chk("abort_oe_idle", bus_if.sda_oe, 0);

        // Asynchronous reset mid-write, during the data-byte ACK
        i2c_start();
        wbyte(8'h20, ack);
        wbyte(8'h07, ack);
        wbits(8'h5A);
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        chk("arst_pre_oe", bus_if.sda_oe, 1);
        chk("arst_pre_word", {bus_if.wr_addr, bus_if.wr_data}, 16'h075A);
        @(negedge clk);
        areset_n = 1'b0;
        #1;
        chk("arst_sda_oe", bus_if.sda_oe, 0);
        chk("arst_busy", bus_if.busy, 0);
        chk("arst_rd_addr", bus_if.rd_addr, 0);
        chk("arst_wr_addr", bus_if.wr_addr, 0);
        chk("arst_wr_data", bus_if.wr_data, 0);
        chk("arst_wr_valid", bus_if.wr_valid, 0);
        m_sda = 1'b1;
        repeat (3) @(negedge clk);
        areset_n = 1'b1;
        q();

        // Loop-back: 65 {reg, data} words written as separate transactions
        base = wv_pulses;
        cyc0 = wv_cycles;
        for (int i = 0; i < 65; i++) begin
            rom_word = {8'(i * 7 + 3), 8'(i * 13) ^ 8'h5C};
            i2c_start();
            wbyte(8'h20, ack);
            wbyte(rom_word[15:8], ack);
            wbyte(rom_word[7:0], ack);
            i2c_stop();
        end
        chk("loop_pulses", wv_pulses - base, 65);
        chk("loop_pulse_width", wv_cycles - cyc0, 65);
        for (int i = 0; i < 65; i++) begin
            rom_word = {8'(i * 7 + 3), 8'(i * 13) ^ 8'h5C};
            chk($sformatf("loop_word%0d", i), wlog[8'(base + i)], rom_word);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
